// File: rtl/cache_control_d.sv
// Control FSM for the two-way write-back L1 data cache: hit response, dirty
// victim writeback, line allocate with replay, plus saturating perf counters.
module cache_control_d #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   hit,
  input  logic                   dirty,
  input  logic                   pmem_resp,
  input  logic                   clear_counters,
  output logic                   mem_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic                   sel_way_mux,
  output logic                   pmem_mux_sel,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count,
  output logic [COUNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state;
  logic   replay;
  logic   req;
  logic   miss_start;
  logic   wb_start;
  logic   hit_event;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] v,
    input logic                   en
  );
    if (en && (v != {COUNT_WIDTH{1'b1}}))
      return v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    return v;
  endfunction

  // A simultaneous read and write is a single access.
  assign req        = mem_read | mem_write;
  assign mem_resp   = (state == IDLE) & req & hit;
  assign miss_start = (state == IDLE) & req & ~hit;
  assign wb_start   = miss_start & dirty;
  assign hit_event  = mem_resp & ~replay;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      replay       <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      sel_way_mux  <= 1'b0;
      pmem_mux_sel <= 1'b0;
      busy         <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      wb_count     <= '0;
    end else begin
      if (clear_counters) begin
        hit_count  <= '0;
        miss_count <= '0;
        wb_count   <= '0;
      end else begin
        hit_count  <= sat_inc(hit_count, hit_event);
        miss_count <= sat_inc(miss_count, miss_start);
        wb_count   <= sat_inc(wb_count, wb_start);
      end

      // Moore outputs are registered alongside the state they belong to.
      case (state)
        IDLE: begin
          if (mem_resp || !req)
            replay <= 1'b0;
          if (miss_start) begin
            busy        <= 1'b1;
            sel_way_mux <= 1'b1;
            if (dirty) begin
              state        <= WRITEBACK;
              pmem_write   <= 1'b1;
              pmem_mux_sel <= 1'b1;
            end else begin
              state     <= ALLOCATE;
              pmem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state        <= ALLOCATE;
            pmem_write   <= 1'b0;
            pmem_mux_sel <= 1'b0;
            pmem_read    <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            state       <= IDLE;
            replay      <= 1'b1;
            pmem_read   <= 1'b0;
            sel_way_mux <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          pmem_read    <= 1'b0;
          pmem_write   <= 1'b0;
          sel_way_mux  <= 1'b0;
          pmem_mux_sel <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_control_d.md
# cache_control_d

Control FSM for the two-way, write-back L1 data cache datapath (`cache_datapath_d`). It sequences the datapath between the CPU-side memory port and physical memory:
- answers hits in the request cycle;
- writes back a dirty LRU victim;
- allocates the missing line, then replays the access as a hit.

It also keeps saturating hit/miss/writeback counters for performance measurement.

## Interface
Parameters:
- `COUNT_WIDTH`, 16, width of each performance counter.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on rising `clk`).
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`.
- `hit`  in  1  datapath: addressed line valid and tag matches in some way.
- `dirty`  in  1  datapath: LRU victim way of indexed set is dirty.
- `pmem_resp`  in  1  physical memory transaction complete (one-cycle pulse).
- `clear_counters`  in  1  synchronous clear of all counters.
- `mem_resp`  out  1  CPU access complete this cycle.
- `pmem_read`  out  1  line-fill read request to physical memory.
- `pmem_write`  out  1  victim writeback request to physical memory.
- `sel_way_mux`  out  1  datapath way select: 0 = hit way, 1 = LRU victim way.
- `pmem_mux_sel`  out  1  pmem address: 0 = CPU `mem_address`, 1 = victim tag address.
- `busy`  out  1  FSM not in IDLE.
- `hit_count`, `miss_count`, `wb_count`  out  `COUNT_WIDTH` each  performance counters.

## Operation
States: IDLE, WRITEBACK, ALLOCATE.

IDLE:
- Outputs: `sel_way_mux`=0, `pmem_mux_sel`=0, `pmem_read`=`pmem_write`=0.
- `mem_resp` = (`mem_read`|`mem_write`) & `hit`. This is combinational (Mealy) and is the only place `mem_resp` is ever 1.
- On request & !`hit` & `dirty` -> WRITEBACK.
- On request & !`hit` & !`dirty` -> ALLOCATE.
- Otherwise stay in IDLE.

WRITEBACK:
- Outputs: `pmem_write`=1, `pmem_mux_sel`=1, `sel_way_mux`=1.
- On `pmem_resp` -> ALLOCATE.

ALLOCATE:
- Outputs: `pmem_read`=1, `pmem_mux_sel`=0, `sel_way_mux`=1.
- On `pmem_resp` -> IDLE, and set `replay`=1.

Replay flag:
- `replay` is an internal register, cleared on reset.
- It is also cleared on any IDLE cycle that asserts `mem_resp` or has no request.

Counters (saturate at all-ones, never wrap):
- `miss_count`: +1 on every IDLE->WRITEBACK or IDLE->ALLOCATE transition.
- `wb_count`: +1 on every IDLE->WRITEBACK transition.
- `hit_count`: +1 on an IDLE `mem_resp` cycle with `replay`=0. The replayed hit after a fill does not count.
- `clear_counters`=1 zeroes all three. It takes priority over any increment in the same cycle.

Boundary conditions:
- `mem_read` & `mem_write` both high is illegal upstream. The FSM treats it as one access and counts it once.
- Request dropped during WRITEBACK/ALLOCATE: the pmem transaction runs to `pmem_resp`, then the FSM returns to IDLE. No `mem_resp` is issued. If the replay is never taken, `replay` clears on the next IDLE cycle with no request.
- `pmem_resp` while in IDLE is ignored.
- Reset mid-transaction: next state is IDLE. All pmem requests drop on the following cycle and the pmem transaction is abandoned.
- WRITEBACK is always entered by a registered transition. This guarantees the datapath's registered victim-tag address has been captured during the IDLE miss cycle before `pmem_mux_sel`=1.

## Timing
Reset values:
- state=IDLE, `replay`=0, all counters=0.
- `pmem_read`=`pmem_write`=`sel_way_mux`=`pmem_mux_sel`=`busy`=0.
- `mem_resp`=0 while no request is present.

Latencies (request presented in cycle 0):
- Hit: `mem_resp` in cycle 0.
- Clean miss, `pmem_resp` after N cycles of `pmem_read`:
  - cycles 1..N in ALLOCATE;
  - cycle N+1 in IDLE with `hit`=1, `mem_resp`=1.
- Dirty miss, writeback taking W cycles and fill taking N cycles:
  - cycles 1..W in WRITEBACK;
  - cycles W+1..W+N in ALLOCATE;
  - `mem_resp` in cycle W+N+1.

Handshakes and output timing:
- pmem requests are Moore outputs, stable from the state-entry cycle until the cycle of `pmem_resp` inclusive.
- The requester must deassert or change its request in the cycle after `mem_resp`. A request still held is treated as a new access.
- Counters update at the rising edge ending the qualifying cycle.

## Test plan
- Hit: reset, then `mem_read`=1, `hit`=1 for 1 cycle -> `mem_resp`=1 same cycle, `hit_count`=1, `busy`=0 throughout.
- Clean miss: `mem_read`=1, `hit`=0, `dirty`=0; `pmem_resp` after 3 cycles; `hit`=1 once back in IDLE -> `pmem_read` high cycles 1–3, `mem_resp` in cycle 4, `miss_count`=1, `hit_count`=0, `wb_count`=0.
- Dirty miss: `mem_write`=1, `hit`=0, `dirty`=1; writeback 2 cycles, fill 2 cycles -> `pmem_write`+`pmem_mux_sel`=1 in cycles 1–2, `pmem_read` in cycles 3–4, `mem_resp` in cycle 5, `miss_count`=1, `wb_count`=1.
- Abort paths:
  - `reset`=0 during cycle 2 of ALLOCATE -> IDLE next cycle, `pmem_read`=0, counters=0.
  - Request dropped during ALLOCATE -> returns to IDLE on `pmem_resp`, `mem_resp` never asserted.
- Saturation/clear: force 2^COUNT_WIDTH+3 hits -> `hit_count`=0xFFFF. Then `clear_counters`=1 coincident with a hit -> `hit_count`=0.
